// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial two's-complement subtractor, Diff = A - B, LSB first.
// One operand bit pair is consumed per SHIFT cycle; a start/busy/done
// handshake frames each operation, and Diff/Borrow hold until the next DONE.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  // One-bit full subtractor on the current LSBs plus the running borrow.
  always_comb begin
    w_a0      = r_a[0];
    w_b0      = r_b[0];
    w_d       = w_a0 ^ w_b0 ^ r_br;
    w_br_nxt  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    w_last    = (r_cnt == CW'(WIDTH - 1));
  end

  // Control FSM, datapath shift registers and registered outputs.
  // Diff/Borrow are loaded from the next-value of the result path on the
  // final SHIFT edge, so they change only when DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Diff    <= '0;
      Borrow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_res <= w_res_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            Diff    <= w_res_nxt;
            Borrow  <= w_br_nxt;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
